// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide engine for the EX stage: shift-add multiply and
// restoring divide, one bit per cycle, with the pipeline stalled while it runs.
module ex_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_valid,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_rs1,
   input  logic [WIDTH-1:0] i_rs2,
   input  logic [4:0]       i_rd,
   input  logic             i_flush,
   output logic             o_stall,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result,
   output logic [4:0]       o_rd,
   output logic [1:0]       o_state
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2:0]         op_q, op_d;
   logic               neg_q, neg_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [4:0]         rd_lat_q, rd_lat_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [4:0]         rd_q, rd_d;

   // Start-time operand decode: magnitudes, signs and the two divide special cases.
   logic               a_signed, b_signed, a_neg, b_neg, is_div, is_rem;
   logic               div_zero, div_ovf;
   logic [WIDTH-1:0]   a_mag, b_mag, special_res;

   always_comb begin
      is_div      = i_op[2];
      is_rem      = i_op[2] & i_op[1];
      a_signed    = (i_op == 3'd1) || (i_op == 3'd2) || (i_op == 3'd4) || (i_op == 3'd6);
      b_signed    = (i_op == 3'd1) || (i_op == 3'd4) || (i_op == 3'd6);
      a_neg       = a_signed & i_rs1[WIDTH-1];
      b_neg       = b_signed & i_rs2[WIDTH-1];
      a_mag       = a_neg ? -i_rs1 : i_rs1;
      b_mag       = b_neg ? -i_rs2 : i_rs2;
      div_zero    = is_div && (i_rs2 == '0);
      div_ovf     = is_div && b_signed && (i_rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (i_rs2 == '1);
      special_res = '0;
      if (div_zero)     special_res = is_rem ? i_rs1 : '1;
      else if (div_ovf) special_res = is_rem ? '0 : i_rs1;
   end

   // One iteration step and the signed result built from the post-step accumulator.
   logic [WIDTH:0]     mul_sum, rem_ext, rem_diff;
   logic [2*WIDTH-1:0] mul_nxt, div_nxt, step_nxt, prod_s;
   logic [WIDTH-1:0]   div_val, final_res;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
      mul_nxt  = {mul_sum, acc_q[WIDTH-1:1]};
      rem_ext  = acc_q[2*WIDTH-1:WIDTH-1];
      rem_diff = rem_ext - {1'b0, b_q};
      if (!rem_diff[WIDTH]) div_nxt = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                  div_nxt = {rem_ext[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      step_nxt = op_q[2] ? div_nxt : mul_nxt;
      prod_s   = neg_q ? -step_nxt : step_nxt;
      div_val  = op_q[1] ? step_nxt[2*WIDTH-1:WIDTH] : step_nxt[WIDTH-1:0];
      if (op_q[2])           final_res = neg_q ? -div_val : div_val;
      else if (op_q == 3'd0) final_res = prod_s[WIDTH-1:0];
      else                   final_res = prod_s[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      neg_d    = neg_q;
      b_d      = b_q;
      acc_d    = acc_q;
      rd_lat_d = rd_lat_q;
      done_d   = 1'b0;
      result_d = result_q;
      rd_d     = rd_q;
      case (state_q)
         S_IDLE: begin
            if (i_valid && !i_flush) begin
               op_d     = i_op;
               rd_lat_d = i_rd;
               if (div_zero || div_ovf) begin
                  result_d = special_res;
                  rd_d     = i_rd;
                  done_d   = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  neg_d   = is_rem ? a_neg : (a_neg ^ b_neg);
                  b_d     = b_mag;
                  acc_d   = {{WIDTH{1'b0}}, a_mag};
                  cnt_d   = CW'(WIDTH - 1);
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            acc_d = step_nxt;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               result_d = final_res;
               rd_d     = rd_lat_q;
               done_d   = 1'b1;
               state_d  = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A flush kills the op wherever it is; the visible result stays untouched.
      if (i_flush) begin
         state_d  = S_IDLE;
         done_d   = 1'b0;
         result_d = result_q;
         rd_d     = rd_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         b_q      <= '0;
         acc_q    <= '0;
         rd_lat_q <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
         rd_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         rd_lat_q <= rd_lat_d;
         done_q   <= done_d;
         result_q <= result_d;
         rd_q     <= rd_d;
      end
   end

   assign o_stall  = ((state_q == S_IDLE) && i_valid) || (state_q == S_CALC);
   assign o_busy   = (state_q != S_IDLE);
   assign o_done   = done_q;
   assign o_result = result_q;
   assign o_rd     = rd_q;
   assign o_state  = state_q;

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative RV32M multiply/divide engine in the EX stage. It consumes operands and rd from the ID/EX pipeline register outputs. While busy it raises a stall that freezes ID/EX and all upstream stages. It presents one result for one cycle so the EX/MEM register can capture it.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
i_valid  in  1  the ID/EX entry is valid and is an M-extension op
i_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
i_rs1  in  WIDTH  operand A (ID/EX RD1 after forwarding)
i_rs2  in  WIDTH  operand B (ID/EX RD2 after forwarding)
i_rd  in  5  destination register
i_flush  in  1  kill the in-flight op (branch mispredict/trap)
o_stall  out  1  hold ID/EX and upstream stages
o_busy  out  1  state != IDLE
o_done  out  1  result valid this cycle
o_result  out  WIDTH  result
o_rd  out  5  rd latched at start

Behaviour:
- States: IDLE, CALC, DONE. Reset (async, reset=0) forces IDLE and clears counter, o_done, o_result, o_rd and o_busy to 0.
- Start condition: IDLE && i_valid && !i_flush. At start, latch i_op, i_rd, operand magnitudes, and result sign.
- Signed ops take absolute values. The final sign is applied in the DONE transition.
  - MULH: both operands signed. MULHSU: rs1 signed, rs2 unsigned. MULHU: both unsigned.
  - DIV/REM: quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
- Normal path: IDLE(T) -> CALC for exactly WIDTH cycles (T+1..T+WIDTH, counter WIDTH-1 down to 0) -> DONE(T+WIDTH+1) -> IDLE.
- Multiply is shift-add into a 2*WIDTH product.
  - MUL returns the low WIDTH bits.
  - MULH, MULHSU and MULHU return the high WIDTH bits of the correctly signed 2*WIDTH product.
- Divide is restoring, one quotient bit per cycle.
- Special cases are detected at start and skip CALC (IDLE(T) -> DONE(T+1)):
  - divide by zero: quotient = all ones; remainder = A.
  - signed overflow (A = 0x80000000, B = -1, DIV/REM): quotient = 0x80000000; remainder = 0.
- o_stall is combinational: (IDLE && i_valid) || CALC. It is 0 in DONE, so the pipeline advances and EX/MEM captures o_result/o_rd.
  - Normal op: o_stall is high for WIDTH+1 cycles.
  - Special case: o_stall is high for 1 cycle.
- o_done is registered, high for exactly one cycle (DONE). o_result and o_rd hold their value until the next DONE.
- i_flush in any state: next state IDLE, no o_done for the killed op. In IDLE, i_flush suppresses a start; o_stall is still asserted combinationally that cycle but has no effect because the flush clears ID/EX.
- DONE followed by i_valid on the next cycle: that is a new instruction and starts normally. DONE itself never starts a new op.
- Reset mid-CALC: immediate IDLE, outputs cleared, no o_done.
- A start with i_op changing mid-operation is ignored; the latched values are used.

Test Plan:
- MUL 7 x 0xFFFFFFFD (start at T) -> o_stall high T..T+32, o_done at T+33, o_result 0xFFFFFFEB, o_rd = i_rd.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2; each with o_done at T+33.
- DIVU 0x1234 / 0 -> 0xFFFFFFFF and REMU -> 0x1234, both with o_done at T+1. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, o_done at T+1.
- Start a DIV, then assert i_flush at T+10 -> IDLE at T+11, o_stall low, no o_done. A new MUL at T+12 completes at T+45 with the correct value.
- reset=0 at T+5 of a MUL -> all outputs 0 immediately. After release, an i_valid DIVU 9/3 -> 3 at T'+33.
